// File: rtl/srt_pkg.sv
// Shared definitions for the SRT divider back-end: digit encoding, FSM states, defaults.
package srt_pkg;
    localparam int WIDTH_DEF = 64;
    localparam int SHW_DEF   = 7;

    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_NEG  = 2'b11;
    localparam logic [1:0] DIG_BAD  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_FIX,
        S_DENORM,
        S_DONE
    } state_e;
endpackage

// File: rtl/srt_otf_conv.sv
// On-the-fly quotient conversion: QA/QM pair kept so that QM == QA-1 at all times.
module srt_otf_conv
    import srt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       digit,
    output logic [WIDTH-1:0] qa,
    output logic [WIDTH-1:0] qm
);
    logic [WIDTH-1:0] qa_q, qa_d, qm_q, qm_d;

    always_comb begin
        qa_d = qa_q;
        qm_d = qm_q;
        if (clr) begin
            qa_d = '0;
            qm_d = '1;
        end else if (en) begin
            case (digit)
                DIG_POS: begin
                    qa_d = {qa_q[WIDTH-2:0], 1'b1};
                    qm_d = {qa_q[WIDTH-2:0], 1'b0};
                end
                DIG_NEG: begin
                    qa_d = {qm_q[WIDTH-2:0], 1'b1};
                    qm_d = {qm_q[WIDTH-2:0], 1'b0};
                end
                // Zero, and the illegal code which is treated as zero.
                default: begin
                    qa_d = {qa_q[WIDTH-2:0], 1'b0};
                    qm_d = {qm_q[WIDTH-2:0], 1'b1};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa_q <= '0;
            qm_q <= '1;
        end else begin
            qa_q <= qa_d;
            qm_q <= qm_d;
        end
    end

    assign qa = qa_q;
    assign qm = qm_q;
endmodule

// File: rtl/srt_qconv.sv
// SRT divider back-end: digit stream to binary quotient, remainder correction and
// denormalization, with Q/R published on a one-cycle DONE.
module srt_qconv
    import srt_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic [SHW-1:0]   SHIFT,
    input  logic [WIDTH-1:0] DSR_NORM,
    input  logic             DIGIT_VALID,
    output logic             DIGIT_READY,
    input  logic [1:0]       DIGIT,
    input  logic             LAST,
    input  logic [WIDTH-1:0] REM_IN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DONE,
    output logic             BUSY,
    output logic             ERR
);
    localparam logic [SHW-1:0] DMAX = SHW'(WIDTH);

    state_e           state_q, state_d;
    logic [SHW-1:0]   shift_q, shift_d, cnt_q, cnt_d, dcnt_q, dcnt_d;
    logic [WIDTH-1:0] dsr_q, dsr_d, rem_q, rem_d, quo_q, quo_d, q_q, q_d, r_q, r_d;
    logic             done_q, done_d, busy_q, busy_d, err_q, err_d, ready_q, ready_d;
    logic             otf_clr, otf_en;
    logic [WIDTH-1:0] otf_qa, otf_qm;

    srt_otf_conv #(.WIDTH(WIDTH)) u_otf (
        .clk   (CLK),
        .rst_n (RSTN),
        .clr   (otf_clr),
        .en    (otf_en),
        .digit (DIGIT),
        .qa    (otf_qa),
        .qm    (otf_qm)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        err_d   = err_q;
        otf_clr = 1'b0;
        otf_en  = 1'b0;
        // START restarts from any state and wins over a digit on the same edge.
        if (START) begin
            state_d = S_CONV;
            shift_d = SHIFT;
            dsr_d   = DSR_NORM;
            dcnt_d  = '0;
            err_d   = 1'b0;
            otf_clr = 1'b1;
        end else begin
            case (state_q)
                S_CONV: if (DIGIT_VALID) begin
                    if (DIGIT == DIG_BAD) err_d = 1'b1;
                    // A digit beyond WIDTH flags an error but leaves QA/QM untouched.
                    if (dcnt_q == DMAX) begin
                        err_d = 1'b1;
                    end else begin
                        otf_en = 1'b1;
                        dcnt_d = dcnt_q + SHW'(1);
                    end
                    if (LAST) begin
                        rem_d   = REM_IN;
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (rem_q[WIDTH-1]) begin
                        rem_d = rem_q + dsr_q;
                        quo_d = otf_qm;
                    end else begin
                        quo_d = otf_qa;
                    end
                    cnt_d   = shift_q;
                    state_d = S_DENORM;
                end
                S_DENORM: begin
                    if (cnt_q != '0) begin
                        rem_d = rem_q >> 1;
                        cnt_d = cnt_q - SHW'(1);
                    end else begin
                        q_d     = quo_q;
                        r_d     = rem_q;
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_CONV);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign DONE        = done_q;
    assign BUSY        = busy_q;
    assign ERR         = err_q;
    assign DIGIT_READY = ready_q;
endmodule
